// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_pkg
//  Brief    : Shared state encodings and state type for the sequential divider.
//  Revision : 1.0  initial release
// ============================================================================
package seq_div_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_CALC = c_st_calc,
        ST_FIX  = c_st_fix,
        ST_DONE = c_st_done
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_if
//  Brief    : Request/result bundle between a requester and seq_div.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_step
//  Brief    : One combinational non-restoring iteration on a WIDTH+1 bit
//             partial remainder and a shifting dividend/quotient word.
//  Revision : 1.0  initial release
// ============================================================================
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_dvs_ext;

    assign w_shifted = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    assign w_dvs_ext = {1'b0, i_dvs};
    // A negative partial remainder is corrected by adding instead of subtracting.
    assign o_rem     = i_rem[WIDTH] ? (w_shifted + w_dvs_ext) : (w_shifted - w_dvs_ext);
    assign o_quo     = {i_quo[WIDTH-2:0], ~o_rem[WIDTH]};
endmodule
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Brief    : Multi-cycle signed/unsigned non-restoring divider, WIDTH+2 latency.
//             Optional macro SEQ_DIV_ZERO_CHECK_EN enables zero-divisor bypass.
//  Revision : 1.0  initial release
// ============================================================================
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SIGNED_DEFAULT = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    seq_div_if.slave  bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    if (WIDTH < 4 || WIDTH > 64 || (SIGNED_DEFAULT != 0 && SIGNED_DEFAULT != 1)) begin : g_bad_param
        $error("seq_div: illegal parameter value");
    end

    state_t               r_state;
    state_t               w_next;
    logic                 w_busy;
    logic                 w_done;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic [WIDTH:0]       w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_neg_n;
    logic                 w_neg_d;

    assign w_neg_n   = bus.sign & bus.dividend[WIDTH-1];
    assign w_neg_d   = bus.sign & bus.divisor[WIDTH-1];
    assign w_rem_fix = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs) : r_rem[WIDTH-1:0];

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nx),
        .o_quo (w_quo_nx)
    );

`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic             r_div_zero;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_raw_dividend;

    // The zero test uses the latched divisor, so the bypass spends one cycle in CALC.
    assign w_dvs_zero     = (r_dvs == '0);
    assign w_raw_dividend = r_neg_r ? -r_quo : r_quo;
    assign bus.div_zero   = r_div_zero;
`else
    assign bus.div_zero   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_busy = 1'b1;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                if (w_dvs_zero) begin
                    w_next = ST_DONE;
                end else
`endif
                if (r_count == c_last) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_busy = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            r_div_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_rem   <= '0;
                        r_quo   <= w_neg_n ? -bus.dividend : bus.dividend;
                        r_dvs   <= w_neg_d ? -bus.divisor  : bus.divisor;
                        r_neg_q <= w_neg_n ^ w_neg_d;
                        r_neg_r <= w_neg_n;
                        r_count <= '0;
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_rem_nx;
                    r_quo   <= w_quo_nx;
                    r_count <= r_count + c_cnt_w'(1);
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    if (w_dvs_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= w_raw_dividend;
                        r_div_zero  <= 1'b1;
                    end
`endif
                end
                ST_FIX: begin
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -w_rem_fix : w_rem_fix;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    r_div_zero  <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Brief    : Scoreboard bench for seq_div at WIDTH=32 and WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_div;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam bit c_zc = 1'b1;
`else
    localparam bit c_zc = 1'b0;
`endif

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          lat;
        int          t0;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb32[$];
    exp_t sb8[$];

    seq_div_if #(.WIDTH(32)) bus32 ();
    seq_div_if #(.WIDTH(8))  bus8 ();

    seq_div #(.WIDTH(32), .SIGNED_DEFAULT(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    seq_div #(.WIDTH(8),  .SIGNED_DEFAULT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model(input int w, input logic sgn, input logic [63:0] a,
                                  input logic [63:0] b, output exp_t e);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        e.lat = w + 2;
        e.dz  = 1'b0;
        if (b == 64'd0) begin
            e.q = mask;
            e.r = a & mask;
            if (c_zc) begin
                e.dz  = 1'b1;
                e.lat = 2;
            end
        end else if (sgn) begin
            sa  = $signed(a << (64 - w)) >>> (64 - w);
            sb  = $signed(b << (64 - w)) >>> (64 - w);
            e.q = 64'(sa / sb) & mask;
            e.r = 64'(sa % sb) & mask;
        end else begin
            e.q = (a / b) & mask;
            e.r = (a % b) & mask;
        end
    endfunction

    // Called at a falling edge; start is sampled by the following rising edge.
    task automatic drive32(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit push);
        exp_t e;
        bus32.start = 1'b1; bus32.sign = sgn; bus32.dividend = a; bus32.divisor = b;
        if (push) begin
            model(32, sgn, 64'(a), 64'(b), e);
            e.t0 = cyc; e.tag = tag;
            sb32.push_back(e);
        end
        @(negedge clk);
        bus32.start = 1'b0; bus32.sign = ~sgn;
        bus32.dividend = $urandom; bus32.divisor = $urandom;
    endtask

    task automatic drive8(input string tag, input logic sgn, input logic [7:0] a,
                          input logic [7:0] b);
        exp_t e;
        bus8.start = 1'b1; bus8.sign = sgn; bus8.dividend = a; bus8.divisor = b;
        model(8, sgn, 64'(a), 64'(b), e);
        e.t0 = cyc; e.tag = tag;
        sb8.push_back(e);
        @(negedge clk);
        bus8.start = 1'b0; bus8.sign = ~sgn;
        bus8.dividend = 8'($urandom); bus8.divisor = 8'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb32.size() == 0 && sb8.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(sb32.size() + sb8.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus32.done) begin
            if (sb32.size() == 0) chk("w32 unexpected done", 64'd1, 64'd0);
            else begin
                e = sb32.pop_front();
                chk({e.tag, " quotient"},  64'(bus32.quotient),  e.q);
                chk({e.tag, " remainder"}, 64'(bus32.remainder), e.r);
                chk({e.tag, " div_zero"},  64'(bus32.div_zero),  64'(e.dz));
                chk({e.tag, " latency"},   64'(cyc - e.t0),      64'(e.lat));
                chk({e.tag, " busy"},      64'(bus32.busy),      64'd0);
            end
        end
        if (bus8.done) begin
            if (sb8.size() == 0) chk("w8 unexpected done", 64'd1, 64'd0);
            else begin
                e = sb8.pop_front();
                chk({e.tag, " quotient"},  64'(bus8.quotient),  e.q);
                chk({e.tag, " remainder"}, 64'(bus8.remainder), e.r);
                chk({e.tag, " latency"},   64'(cyc - e.t0),     64'(e.lat));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst_n = 1'b0;
        bus32.start = 1'b0; bus32.sign = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
        bus8.start  = 1'b0; bus8.sign  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy",      64'(bus32.busy),      64'd0);
        chk("reset done",      64'(bus32.done),      64'd0);
        chk("reset quotient",  64'(bus32.quotient),  64'd0);
        chk("reset remainder", 64'(bus32.remainder), 64'd0);
        chk("reset div_zero",  64'(bus32.div_zero),  64'd0);

        // First start offered right as reset releases.
        rst_n = 1'b1;
        drive32("u100/7", 1'b0, 32'd100, 32'd7, 1'b1);
        chk("busy in calc", 64'(bus32.busy), 64'd1);
        wait_drain();
        repeat (5) @(negedge clk);
        chk("hold quotient",  64'(bus32.quotient),  64'd14);
        chk("hold remainder", 64'(bus32.remainder), 64'd2);

        drive32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_drain();
        drive32("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_drain();
        drive32("u5/0", 1'b0, 32'd5, 32'd0, 1'b1);
        wait_drain();

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 300));
            if (b == 32'd0) b = 32'd1;
            s = 1'(i % 3 != 0);
            drive32($sformatf("rand%0d", i), s, a, b, 1'b1);
            wait_drain();
        end

        // A start offered mid-operation must be dropped, not queued.
        drive32("u1000/33", 1'b0, 32'd1000, 32'd33, 1'b1);
        repeat (3) @(negedge clk);
        drive32("ignored", 1'b0, 32'd9, 32'd3, 1'b0);
        wait_drain();
        repeat (40) @(negedge clk);
        chk("no queued start", 64'(bus32.busy), 64'd0);

        drive8("w8 255/16", 1'b0, 8'd255, 8'd16);
        wait_drain();
        drive8("w8 min/-1", 1'b1, 8'h80, 8'hFF);
        wait_drain();
        drive8("w8 -128/3", 1'b1, 8'h80, 8'd3);
        wait_drain();

        // Reset in the middle of an operation aborts it without a done pulse.
        drive32("abort", 1'b0, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        drive32("ignored2", 1'b0, 32'd9, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy",      64'(bus32.busy),      64'd0);
        chk("abort done",      64'(bus32.done),      64'd0);
        chk("abort quotient",  64'(bus32.quotient),  64'd0);
        chk("abort remainder", 64'(bus32.remainder), 64'd0);
        chk("abort div_zero",  64'(bus32.div_zero),  64'd0);
        chk("abort w8 quotient", 64'(bus8.quotient), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post-abort idle",     64'(bus32.busy),     64'd0);
        chk("post-abort quotient", 64'(bus32.quotient), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
